// File: rtl/mips_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation encoding,
// FSM states and the default operand width.
package mips_muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step on a 2*WIDTH accumulator.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 i_mode,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic                 o_qbit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;

  // Remainder stays below twice the divisor, so a WIDTH-bit difference is exact
  // whenever the trial subtract succeeds.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh[WIDTH-1:0] - i_operand;
    o_qbit   = (w_rem_sh >= {1'b0, i_operand});
    if (i_mode) begin
      o_acc = {(o_qbit ? w_diff : w_rem_sh[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the MIPS HI/LO registers,
// including MTHI/MTLO writes while idle.
module mips_hilo_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             r_state, w_state_nxt;
  muldiv_op_t         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_opnd, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc, w_step_acc, w_acc_nxt, w_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q, r_neg_r, r_busy, r_done, r_dbz;
  logic               w_qbit, w_is_div, w_signed, w_sa, w_sb;
  logic               w_accept, w_mt_ok, w_last;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;

  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_is_div = (r_op == DIV) || (r_op == DIVU);
  assign w_signed = (r_op == MULT) || (r_op == DIV);
  assign w_sa     = w_signed & r_a[WIDTH-1];
  assign w_sb     = w_signed & r_b[WIDTH-1];

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_mode    (w_is_div),
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .o_acc     (w_step_acc),
    .o_qbit    (w_qbit)
  );

  assign w_acc_nxt = {w_step_acc[2*WIDTH-1:1], (w_is_div ? w_qbit : w_step_acc[0])};

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = PREP;
      PREP:    w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- FSM: control strobes ----
  always_comb begin
    w_accept = (r_state == IDLE) && start;
    w_mt_ok  = (r_state == IDLE);
    w_last   = (r_state == RUN) && (r_cnt == CNT_W'(1));
  end

  // Results are formed from the final iteration so HI/LO land as FIX is entered,
  // coincident with done.
  always_comb begin
    w_prod   = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (w_is_div) begin
      if (r_dbz) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = f_cneg(w_acc_nxt[2*WIDTH-1:WIDTH], r_neg_r);
        w_res_lo = f_cneg(w_acc_nxt[WIDTH-1:0], r_neg_q);
      end
    end
  end

  // ---- datapath and HI/LO registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == FIX);
      if (w_accept) begin
        r_op  <= muldiv_op_t'(op);
        r_a   <= op_a;
        r_b   <= op_b;
        r_dbz <= op[1] && (op_b == '0);
      end
      if (r_state == PREP) begin
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_cnt   <= CNT_W'(WIDTH);
        if (w_is_div) begin
          r_acc  <= {{WIDTH{1'b0}}, f_cneg(r_a, w_sa)};
          r_opnd <= f_cneg(r_b, w_sb);
        end else begin
          r_acc  <= {{WIDTH{1'b0}}, f_cneg(r_b, w_sb)};
          r_opnd <= f_cneg(r_a, w_sa);
        end
      end
      if (r_state == RUN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_ok) begin
        if (mthi) r_hi <= mt_data;
        if (mtlo) r_lo <= mt_data;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// Self-checking bench: directed table, randomized ops against an arithmetic
// reference, and hand sequences for MT/reset/WIDTH=8 corner cases.
module tb_mips_hilo_muldiv;
  import mips_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] op_a, op_b, mt_data, hi, lo;
  logic        busy, done, div_by_zero;

  logic        s8_start, s8_mthi, s8_mtlo;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_mt, s8_hi, s8_lo;
  logic        s8_busy, s8_done, s8_dbz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_hilo_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  mips_hilo_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op), .op_a(s8_a), .op_b(s8_b),
    .mthi(s8_mthi), .mtlo(s8_mtlo), .mt_data(s8_mt), .busy(s8_busy), .done(s8_done),
    .div_by_zero(s8_dbz), .hi(s8_hi), .lo(s8_lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder follows the dividend, as MIPS requires.
  task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mhi, output logic [31:0] mlo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      2'd0: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          mhi = a; mlo = 32'hFFFF_FFFF;
        end else if (mop == 2'd2) begin
          q = sa / sb; r = sa % sb;
          mhi = r[31:0]; mlo = q[31:0];
        end else begin
          mhi = a % b; mlo = a / b;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input bit mth,
                        output logic [31:0] rhi, output logic [31:0] rlo, output int dcyc,
                        output int ndone, output int busy_err, output logic dbz1,
                        output logic [31:0] hi_mid);
    @(posedge clk); #1;
    start = 1'b1; op = op_i; op_a = a; op_b = b; mthi = mth; mt_data = 32'h1234;
    rhi = '0; rlo = '0; dcyc = -1; ndone = 0; busy_err = 0; dbz1 = 1'b0; hi_mid = '0;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (c == 1) dbz1 = div_by_zero;
      if (c == 5) hi_mid = hi;
      if (busy !== (c <= 34)) busy_err++;
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; rhi = hi; rlo = lo; end
      end
      if (c == inj) begin
        start = 1'b1; op = MULTU; op_a = $urandom; op_b = $urandom;
        mtlo = 1'b1; mt_data = 32'hAA;
      end
    end
  endtask

  initial begin
    logic [31:0] rhi, rlo, mhi, mlo, hmid, ra, rb;
    logic [1:0]  rop;
    logic        dbz1;
    int          dcyc, ndone, berr, cnt;

    reset = 1'b1; start = 0; op = 0; op_a = 0; op_b = 0; mthi = 0; mtlo = 0; mt_data = 0;
    s8_start = 0; s8_op = 0; s8_a = 0; s8_b = 0; s8_mthi = 0; s8_mtlo = 0; s8_mt = 0;

    tbl[0] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    tbl[5] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    tbl[6] = '{DIVU,  32'd9,         32'd4,         32'd1,         32'd2,         1'b0};
    tbl[7] = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    tbl[8] = '{DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 0); chk("reset_lo", lo, 0); chk("reset_busy", busy, 0);
    chk("reset_done", done, 0); chk("reset_dbz", div_by_zero, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, 1'b0, rhi, rlo, dcyc, ndone, berr, dbz1, hmid);
      chk($sformatf("tbl%0d_hi", i), rhi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), rlo, tbl[i].lo);
      chk($sformatf("tbl%0d_done_cycle", i), dcyc, 34);
      chk($sformatf("tbl%0d_done_pulses", i), ndone, 1);
      chk($sformatf("tbl%0d_busy_profile_errs", i), berr, 0);
      chk($sformatf("tbl%0d_dbz_cycle1", i), dbz1, tbl[i].dbz);
      if (tbl[i].dbz) chk($sformatf("tbl%0d_dbz_sticky", i), div_by_zero, 1);
    end

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, mhi, mlo);
      run_op(rop, ra, rb, 0, 1'b0, rhi, rlo, dcyc, ndone, berr, dbz1, hmid);
      chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, rop, ra, rb), rhi, mhi);
      chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, rop, ra, rb), rlo, mlo);
      chk($sformatf("rnd%0d_done_cycle", i), dcyc, 34);
      chk($sformatf("rnd%0d_dbz", i), dbz1, rop[1] && (rb == 32'd0));
    end

    // MTHI and MTLO together while idle
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_idle_hi", hi, 32'hDEAD_BEEF);
    chk("mt_idle_lo", lo, 32'hDEAD_BEEF);

    // MTHI alongside the start; a second start and MTLO mid-RUN must be ignored
    run_op(DIVU, 32'd9, 32'd4, 10, 1'b1, rhi, rlo, dcyc, ndone, berr, dbz1, hmid);
    chk("mt_start_hi_before_done", hmid, 32'h1234);
    chk("mt_start_hi", rhi, 32'd1);
    chk("mt_start_lo", rlo, 32'd2);
    chk("mt_start_done_cycle", dcyc, 34);
    chk("mt_start_done_pulses", ndone, 1);
    chk("mt_start_busy_profile_errs", berr, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) cnt++;
    end
    chk("no_queued_op", cnt, 0);

    // Reset in the middle of RUN discards the op
    @(posedge clk); #1;
    start = 1'b1; op = MULT; op_a = 32'h1234_5678; op_b = 32'h0000_0777;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("busy_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_hi", hi, 0);
    chk("midrun_reset_lo", lo, 0);
    chk("midrun_reset_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) cnt++;
    end
    chk("midrun_reset_no_resume", cnt, 0);
    chk("midrun_reset_hi_after", hi, 0);

    // WIDTH=8 build: latency WIDTH+2 = 10
    @(posedge clk); #1;
    s8_start = 1'b1; s8_op = MULT; s8_a = 8'h80; s8_b = 8'h80;
    dcyc = -1; rhi = '0; rlo = '0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      s8_start = 1'b0;
      if (s8_done === 1'b1 && dcyc < 0) begin
        dcyc = c; rhi = {24'd0, s8_hi}; rlo = {24'd0, s8_lo};
      end
    end
    chk("w8_done_cycle", dcyc, 10);
    chk("w8_hi", rhi, 32'h40);
    chk("w8_lo", rlo, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_hilo_muldiv.md
Name: mips_hilo_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit owning the HI/LO special registers of the MIPS core.
- Executes MULT, MULTU, DIV, DIVU iteratively: one partial product or one quotient bit per cycle.
- Also services MTHI/MTLO writes.
- Sits beside the ALU in mips_cpu_bus. The control unit launches an operation, stalls MFHI/MFLO on busy, and reads hi/lo directly.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch request; sampled only when busy=0.
- op  input  2  operation, muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3.
- op_a  input  WIDTH  rs value (multiplicand / dividend).
- op_b  input  WIDTH  rt value (multiplier / divisor).
- mthi  input  1  write mt_data to HI.
- mtlo  input  1  write mt_data to LO.
- mt_data  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in flight; control unit must stall MFHI/MFLO/new muldiv.
- done  output  1  one-cycle pulse, coincident with HI/LO update.
- div_by_zero  output  1  sticky flag; set when a DIV/DIVU starts with op_b=0, cleared by the next accepted start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, internal datapath regs cleared. An operation in flight is discarded; no partial HI/LO write occurs.
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE, start=1: capture op/op_a/op_b -> PREP. busy rises the next cycle.
- PREP (1 cycle):
  - Signed ops store |op_a|, |op_b| and result-sign flags.
  - Unsigned ops store operands raw.
  - counter=WIDTH.
  -> RUN.
- RUN (exactly WIDTH cycles):
  - Multiply: shift-add. Accumulator is 2*WIDTH bits; test the multiplier LSB and add the multiplicand into the upper half, then shift right 1.
  - Divide: restoring. Shift {rem,quot} left 1, trial subtract the divisor from rem. If no borrow, keep the result and set the quotient LSB.
  - Counter decrements; at 0 -> FIX.
- FIX (1 cycle): apply sign fixup (two's-complement negate), write hi/lo, done=1 -> IDLE.
  - Product: negate if signs differ.
  - Quotient: negate if signs differ.
  - Remainder: takes the dividend's sign.
- Latency: start accepted in cycle 0 -> done=1 and hi/lo valid in cycle WIDTH+2. busy=1 in cycles 1..WIDTH+2, back to 0 in cycle WIDTH+3, when a new start may be accepted. Back-to-back throughput: one op per WIDTH+3 cycles.
- Result mapping: MULT/MULTU gives hi=product[2W-1:W], lo=product[W-1:0]. DIV/DIVU gives lo=quotient, hi=remainder.
- Divide by zero: the operation runs the full latency, with no early exit.
  - Result: lo={WIDTH{1'b1}}, hi=op_a as captured.
  - div_by_zero is set in cycle 1.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0, no flag.
- MULT of most-negative × most-negative: hi=0x4000_0000, lo=0 (WIDTH=32). No overflow exists in the 2W product.
- start while busy=1: ignored, no queuing.
- mthi/mtlo while busy=1: ignored; the result write in FIX wins.
- mthi/mtlo in IDLE: hi/lo take mt_data the next cycle. mthi and mtlo together write both.
- mthi with start in the same IDLE cycle: the mt write occurs; the later FIX write overwrites it.
- done never asserts outside FIX. busy and done are both registered outputs.

Decomposition:
- Package mips_muldiv_pkg holds muldiv_op_t (2-bit enum), state_t (IDLE/PREP/RUN/FIX), and the WIDTH default constant.
- One sub-module, mips_muldiv_step: combinational single-iteration datapath. Inputs are mode, acc, operand; outputs are next acc and quotient bit. It is instantiated once and shared by multiply and divide.
- FSM, sign handling and HI/LO registers stay in the top module.

Test Plan:
- MULTU 0xFFFF_FFFF×0xFFFF_FFFF -> done at cycle 34, hi=0xFFFF_FFFE, lo=0x0000_0001; busy high cycles 1..34.
- MULT -7×3 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU 100/0 -> div_by_zero=1 from cycle 1, lo=0xFFFF_FFFF, hi=100. The next accepted start clears the flag.
- DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- mthi 0x1234 in IDLE then start DIVU 9/4; a second start and mtlo 0xAA issued mid-RUN are ignored.
  - Required: hi=0x1234 before done; hi=1, lo=2 at done; no second op runs.
- Reset asserted at RUN cycle 10 of MULT -> hi=lo=0, busy=0 immediately. A rerun with WIDTH=8 parameter build, MULT 0x80×0x80, gives hi=0x40, lo=0x00 at cycle 10.
